seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for the 4-digit common-anode 7-segment display, downstream of the
//  28-bit segment-array encoder. Scans one digit at a time with blanking dead-time, latches the

---
 rtl/seg_scan_driver_pkg.sv | 36 +++
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver_tick_counter.sv | 36 +++
 rtl/seg_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg_scan_driver.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, state encoding and digit helpers for the 4-digit scan driver.
package seg_scan_driver_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;
   localparam int ARRAY_W    = NUM_DIGITS * SEG_W;
   localparam int IDX_W      = 2;

   // Display is common-anode: both anodes and segments are active-low.
   localparam logic ANODE_ON = 1'b0;
   localparam logic SEG_ON   = 1'b0;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Pick the 7-bit code of digit k out of the array; k=0 is the leftmost digit (MSBs).
   function automatic logic [SEG_W-1:0] digit_code(input logic [ARRAY_W-1:0] arr,
                                                    input logic [IDX_W-1:0]   k);
      logic [SEG_W-1:0] code;
      case (k)
         2'd0:    code = arr[27:21];
         2'd1:    code = arr[20:14];
         2'd2:    code = arr[13:7];
         default: code = arr[6:0];
      endcase
      return code;
   endfunction

   // Convert a 1=lit segment code into the physical pin polarity.
   function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] code);
      return code ^ {SEG_W{~SEG_ON}};
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle of display-content inputs and pin-level outputs of the scan driver.
interface seg_scan_driver_if;
   import seg_scan_driver_pkg::*;

   logic [ARRAY_W-1:0]    seg_array;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  blink_en;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic [NUM_DIGITS-1:0] an;
   logic [SEG_W-1:0]      cathode;
   logic                  dp;
   logic                  frame_done;

   // Source of display content / consumer of the pins.
   modport master (
      output seg_array, dp_mask, blink_en, blink_mask,
      input  an, cathode, dp, frame_done
   );

   // The scan driver itself.
   modport slave (
      input  seg_array, dp_mask, blink_en, blink_mask,
      output an, cathode, dp, frame_done
   );
endinterface

// File: rtl/seg_scan_driver_tick_counter.sv
// Free-running modulo-TERM counter with synchronous clear and a 1-cycle terminal tick.
module seg_tick_counter #(
   parameter int TERM = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   // A terminal count of 1 still needs a 1-bit register to keep the port widths legal.
   localparam int            CW   = (TERM > 1) ? $clog2(TERM) : 1;
   localparam logic [CW-1:0] LAST = CW'(TERM - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count up, wrap to zero on the terminal value, hold at zero while cleared.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blanking, per-frame latching
// of the display content and per-digit blinking.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               resetn,   // active-high synchronous reset despite the name
   seg_scan_driver_if.slave   bus
);

   scan_state_e           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ARRAY_W-1:0]    frame_seg_q, frame_seg_d;
   logic [NUM_DIGITS-1:0] frame_dp_q, frame_dp_d;
   logic [NUM_DIGITS-1:0] frame_bmask_q, frame_bmask_d;
   logic                  frame_ben_q, frame_ben_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]      cathode_q, cathode_d;
   logic                  dp_q, dp_d;
   logic                  frame_done_q, frame_done_d;

   logic blank_tick, digit_tick, blink_tick;
   logic hidden;

   // Each phase timer restarts from zero whenever the FSM is outside its phase.
   seg_tick_counter #(.TERM(BLANK_CYCLES)) u_blank_timer (
      .clk (clk), .rst (resetn), .clr (state_q != ST_BLANK), .tick (blank_tick)
   );

   seg_tick_counter #(.TERM(DIGIT_CYCLES)) u_digit_timer (
      .clk (clk), .rst (resetn), .clr (state_q != ST_DRIVE), .tick (digit_tick)
   );

   // Blink prescaler runs freely, independent of frame timing.
   seg_tick_counter #(.TERM(BLINK_CYCLES)) u_blink_prescaler (
      .clk (clk), .rst (resetn), .clr (1'b0), .tick (blink_tick)
   );

   // Next-state logic: scan sequencing, frame capture at the start of digit 0, blink phase.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      frame_seg_d   = frame_seg_q;
      frame_dp_d    = frame_dp_q;
      frame_bmask_d = frame_bmask_q;
      frame_ben_d   = frame_ben_q;
      blink_phase_d = blink_phase_q ^ blink_tick;
      frame_done_d  = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (blank_tick) begin
               state_d = ST_DRIVE;
               // Latch the whole frame only here so a frame never mixes old and new content.
               if (idx_q == '0) begin
                  frame_seg_d   = bus.seg_array;
                  frame_dp_d    = bus.dp_mask;
                  frame_bmask_d = bus.blink_mask;
                  frame_ben_d   = bus.blink_en;
               end
            end
         end
         ST_DRIVE: begin
            if (digit_tick) begin
               state_d      = ST_BLANK;
               idx_d        = idx_q + 1'b1;
               frame_done_d = (idx_q == IDX_W'(NUM_DIGITS - 1));
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Pin values for the current slot; a hidden digit keeps its slot timing but stays dark.
   always_comb begin
      hidden    = frame_ben_d == frame_ben_q ? (frame_ben_q && frame_bmask_q[2'd3 - idx_q] && blink_phase_q)
                                             : (frame_ben_q && frame_bmask_q[2'd3 - idx_q] && blink_phase_q);
      an_d      = {NUM_DIGITS{~ANODE_ON}};
      cathode_d = {SEG_W{~SEG_ON}};
      dp_d      = ~SEG_ON;
      if (state_q == ST_DRIVE && !hidden) begin
         an_d[2'd3 - idx_q] = ANODE_ON;
         cathode_d          = seg_drive(digit_code(frame_seg_q, idx_q));
         dp_d               = frame_dp_q[2'd3 - idx_q] ? SEG_ON : ~SEG_ON;
      end
   end

   // All state, frame latches and output pins.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q       <= ST_BLANK;
         idx_q         <= '0;
         frame_seg_q   <= '0;
         frame_dp_q    <= '0;
         frame_bmask_q <= '0;
         frame_ben_q   <= 1'b0;
         blink_phase_q <= 1'b0;
         an_q          <= {NUM_DIGITS{~ANODE_ON}};
         cathode_q     <= {SEG_W{~SEG_ON}};
         dp_q          <= ~SEG_ON;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         frame_seg_q   <= frame_seg_d;
         frame_dp_q    <= frame_dp_d;
         frame_bmask_q <= frame_bmask_d;
         frame_ben_q   <= frame_ben_d;
         blink_phase_q <= blink_phase_d;
         an_q          <= an_d;
         cathode_q     <= cathode_d;
         dp_q          <= dp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.cathode    = cathode_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIGIT_CYCLES=4, BLANK_CYCLES=1, BLINK_CYCLES=16.
module tb_seg_scan_driver;

   localparam int DIGIT_CYCLES = 4;
   localparam int BLANK_CYCLES = 1;
   localparam int BLINK_CYCLES = 16;
   localparam int SLOT         = DIGIT_CYCLES + BLANK_CYCLES;
   localparam int FRAME        = 4 * SLOT;

   // One display setting plus the pin values it must produce per digit (leftmost first).
   typedef struct {
      logic [27:0] seg;
      logic [3:0]  dpm;
      logic        ben;
      logic [3:0]  bmask;
      logic [27:0] cath;   // {cath0,cath1,cath2,cath3}, active-low
      logic [3:0]  dpo;    // bit3 = leftmost, active-low
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] cath;
      logic       dp;
      logic       fd;
   } obs_t;

   logic clk = 1'b0;
   logic resetn;

   seg_scan_driver_if bus ();

   seg_scan_driver #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .BLINK_CYCLES (BLINK_CYCLES)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   vec_t tbl [7];
   obs_t exp_q [$];
   vec_t cur, cap;
   int   checks   = 0;
   int   failures = 0;
   int   e        = 0;   // edges since reset release

   task automatic apply(input int i);
      cur            = tbl[i];
      bus.seg_array  = cur.seg;
      bus.dp_mask    = cur.dpm;
      bus.blink_en   = cur.ben;
      bus.blink_mask = cur.bmask;
   endtask

   // Expected pins after edge number en, from slot position and blink window.
   function automatic obs_t predict(input int en, input vec_t c);
      obs_t o;
      int   q, k;
      bit   ph;
      o.an   = 4'hF;
      o.cath = 7'h7F;
      o.dp   = 1'b1;
      q      = (en - 1) % FRAME;
      ph     = (((en - 1) / BLINK_CYCLES) % 2) == 1;
      o.fd   = (q == FRAME - 1);
      if (q % SLOT != 0) begin
         k = q / SLOT;
         if (!(c.ben && c.bmask[3-k] && ph)) begin
            o.an[3-k] = 1'b0;
            o.cath    = c.cath[27-7*k -: 7];
            o.dp      = c.dpo[3-k];
         end
      end
      return o;
   endfunction

   task automatic compare(input string name);
      obs_t got, ex;
      got = {bus.an, bus.cathode, bus.dp, bus.frame_done};
      ex  = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
         failures++;
         $display("FAIL %s edge=%0d got an=%b cath=%h dp=%b fd=%b required an=%b cath=%h dp=%b fd=%b",
                  name, e, got.an, got.cath, got.dp, got.fd, ex.an, ex.cath, ex.dp, ex.fd);
      end
   endtask

   task automatic step(input string name);
      e++;
      if ((e - 1) % FRAME == 0) cap = cur;
      exp_q.push_back(predict(e, cap));
      @(posedge clk);
      #1;
      compare(name);
   endtask

   task automatic reset_step(input string name);
      obs_t r;
      r.an = 4'hF; r.cath = 7'h7F; r.dp = 1'b1; r.fd = 1'b0;
      exp_q.push_back(r);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      compare(name);
      e = 0;
   endtask

   initial begin
      tbl[0] = '{seg:{7'h3F,7'h06,7'h5B,7'h4F}, dpm:4'b0100, ben:1'b0, bmask:4'b0000,
                 cath:{7'h40,7'h79,7'h24,7'h30}, dpo:4'b1011};
      tbl[1] = '{seg:{7'h7F,7'h7F,7'h7F,7'h7F}, dpm:4'b0000, ben:1'b0, bmask:4'b0000,
                 cath:{7'h00,7'h00,7'h00,7'h00}, dpo:4'b1111};
      tbl[2] = '{seg:28'h0, dpm:4'b0000, ben:1'b0, bmask:4'b0000,
                 cath:{7'h7F,7'h7F,7'h7F,7'h7F}, dpo:4'b1111};
      tbl[3] = '{seg:{7'h6D,7'h7D,7'h07,7'h6F}, dpm:4'b1001, ben:1'b0, bmask:4'b0000,
                 cath:{7'h12,7'h02,7'h78,7'h10}, dpo:4'b0110};
      tbl[4] = '{seg:{7'h3F,7'h06,7'h5B,7'h4F}, dpm:4'b0100, ben:1'b1, bmask:4'b0001,
                 cath:{7'h40,7'h79,7'h24,7'h30}, dpo:4'b1011};
      tbl[5] = '{seg:{7'h6D,7'h7D,7'h07,7'h6F}, dpm:4'b1001, ben:1'b1, bmask:4'b1010,
                 cath:{7'h12,7'h02,7'h78,7'h10}, dpo:4'b0110};
      tbl[6] = '{seg:{7'h6D,7'h7D,7'h07,7'h6F}, dpm:4'b1001, ben:1'b0, bmask:4'b1111,
                 cath:{7'h12,7'h02,7'h78,7'h10}, dpo:4'b0110};

      apply(0);
      cap = cur;
      reset_step("reset_hold0");
      reset_step("reset_hold1");
      resetn = 1'b0;

      // Each table setting for three full frames (covers both blink windows).
      for (int i = 0; i < 7; i++) begin
         apply(i);
         for (int c = 0; c < 3 * FRAME; c++) step($sformatf("vec%0d", i));
      end

      // Content change while digit 2 is on screen must wait for the next frame.
      apply(0);
      for (int c = 0; c < 12; c++) step("midframe_before");
      apply(1);
      for (int c = 0; c < 2 * FRAME - 12; c++) step("midframe_after");

      // Reset pulse during digit 2, then the scan restarts from a blank slot.
      for (int c = 0; c < 12; c++) step("pre_reset");
      reset_step("reset_mid_drive");
      resetn = 1'b0;
      apply(3);
      for (int c = 0; c < 2 * FRAME; c++) step("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
